// File: rtl/conv3x3_filter_pkg.sv
// Shared definitions for the 3x3 convolution stage: kernel mode encodings,
// pipeline constants and the output clamp helper.
package conv3x3_pkg;

  typedef enum logic [2:0] {
    MODE_PASS  = 3'd0,
    MODE_BLUR  = 3'd1,
    MODE_SOBX  = 3'd2,
    MODE_SOBY  = 3'd3,
    MODE_LAP   = 3'd4,
    MODE_SHARP = 3'd5,
    MODE_MAG   = 3'd6,
    MODE_PASS7 = 3'd7
  } mode_e;

  localparam int PIPE_LAT   = 3;
  localparam int BLUR_RECIP = 7282;

  function automatic int saturate(input int v, input int width);
    int max_v;
    int res;
    max_v = (1 << width) - 1;
    if (v < 0)
      res = 0;
    else if (v > max_v)
      res = max_v;
    else
      res = v;
    return res;
  endfunction

endpackage

// File: rtl/conv3x3_filter_if.sv
// Pixel stream bundle: packed pixel word plus hsync/vsync/active-video enable.
interface conv3x3_filter_if #(parameter int DW = 24);
  logic [DW-1:0] data;
  logic          hsync;
  logic          vsync;
  logic          vde;

  modport master (output data, hsync, vsync, vde);
  modport slave  (input  data, hsync, vsync, vde);
endinterface

// File: rtl/conv3x3_filter_line_buffer.sv
// One line of pixel storage: simple dual-port RAM with a registered read port.
module conv_line_buffer #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 2200,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/conv3x3_filter.sv
// 3x3 spatial convolution on a packed multi-channel pixel stream with zero-filled
// borders and sync lines delayed to match. Define CONV_SOBEL_MAG_EN to turn mode 6 into gradient magnitude.
module conv3x3_filter
  import conv3x3_pkg::*;
#(
  parameter int CHANNELS   = 3,
  parameter int CH_WIDTH   = 8,
  parameter int LINE_LEN   = 2200,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                    clk,
  input  logic                    n_rst,
  conv3x3_filter_if.slave         vid_in,
  conv3x3_filter_if.master        vid_out,
  input  logic [2:0]              mode,
  output logic [2:0]              o_mode_active
);

  localparam int PIX_W = CHANNELS * CH_WIDTH;
  localparam int SUM_W = CH_WIDTH + 5;

  logic                  vsync_q, vde_q;
  logic                  vsync_rise, vde_fall;
  logic [ADDR_WIDTH-1:0] col_cnt;
  logic [1:0]            row_cnt;

  logic [PIX_W-1:0]      pix_s1, rd1, rd2;
  logic [ADDR_WIDTH-1:0] col_s1, win_col;
  logic [1:0]            row_s1;
  logic                  vde_s1;

  logic [2:0][2:0][PIX_W-1:0] win, win_g;
  logic [PIX_W-1:0]           filt, data_q;
  logic [PIPE_LAT-1:0]        hs_dly, vs_dly, vde_dly;

  assign vsync_rise = vid_in.vsync & ~vsync_q;
  assign vde_fall   = ~vid_in.vde & vde_q;

  // Row count only needs to distinguish rows 0, 1 and "2 or later" for zero-fill.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      vsync_q       <= 1'b0;
      vde_q         <= 1'b0;
      col_cnt       <= '0;
      row_cnt       <= '0;
      o_mode_active <= 3'd0;
    end else begin
      vsync_q <= vid_in.vsync;
      vde_q   <= vid_in.vde;
      col_cnt <= vid_in.vde ? col_cnt + 1'b1 : '0;
      if (vsync_rise)
        row_cnt <= '0;
      else if (vde_fall && row_cnt != 2'd3)
        row_cnt <= row_cnt + 2'd1;
      if (vsync_rise)
        o_mode_active <= mode;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      pix_s1 <= '0;
      col_s1 <= '0;
      row_s1 <= '0;
      vde_s1 <= 1'b0;
    end else begin
      pix_s1 <= vid_in.data;
      col_s1 <= col_cnt;
      row_s1 <= row_cnt;
      vde_s1 <= vid_in.vde;
    end
  end

  // buf1 holds the previous line; buf2 is fed from buf1's read data so it lags one more line.
  conv_line_buffer #(.DATA_W(PIX_W), .DEPTH(LINE_LEN), .ADDR_W(ADDR_WIDTH)) u_buf1 (
    .clk   (clk),
    .we    (vde_s1),
    .waddr (col_s1),
    .wdata (pix_s1),
    .raddr (col_cnt),
    .rdata (rd1)
  );

  conv_line_buffer #(.DATA_W(PIX_W), .DEPTH(LINE_LEN), .ADDR_W(ADDR_WIDTH)) u_buf2 (
    .clk   (clk),
    .we    (vde_s1),
    .waddr (col_s1),
    .wdata (rd1),
    .raddr (col_cnt),
    .rdata (rd2)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      win     <= '0;
      win_col <= '0;
    end else if (vde_s1) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= (row_s1 >= 2'd2) ? rd2 : '0;
      win[1][2] <= (row_s1 >= 2'd1) ? rd1 : '0;
      win[2][2] <= pix_s1;
      win_col   <= col_s1;
    end
  end

  // Older window columns still hold the previous line's tail until col reaches 2.
  always_comb begin
    win_g = win;
    if (win_col < ADDR_WIDTH'(2)) begin
      win_g[0][0] = '0;
      win_g[1][0] = '0;
      win_g[2][0] = '0;
    end
    if (win_col < ADDR_WIDTH'(1)) begin
      win_g[0][1] = '0;
      win_g[1][1] = '0;
      win_g[2][1] = '0;
    end
  end

  function automatic logic [SUM_W-1:0] abs_s(input logic signed [SUM_W-1:0] v);
    return v[SUM_W-1] ? -v : v;
  endfunction

  function automatic logic [CH_WIDTH-1:0] filt_ch(input logic [2:0][2:0][CH_WIDTH-1:0] p,
                                                  input logic [2:0] md);
    logic signed [SUM_W-1:0] t [3][3];
    logic signed [SUM_W-1:0] sum, gx, gy, nb, c4, ax, ay, lap;
    int res;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        t[r][c] = signed'({5'b0, p[r][c]});
    sum = t[0][0] + t[0][1] + t[0][2] + t[1][0] + t[1][1] + t[1][2]
        + t[2][0] + t[2][1] + t[2][2];
    gx  = (t[0][2] + t[1][2] + t[1][2] + t[2][2]) - (t[0][0] + t[1][0] + t[1][0] + t[2][0]);
    gy  = (t[2][0] + t[2][1] + t[2][1] + t[2][2]) - (t[0][0] + t[0][1] + t[0][1] + t[0][2]);
    nb  = t[0][1] + t[2][1] + t[1][0] + t[1][2];
    c4  = t[1][1] + t[1][1] + t[1][1] + t[1][1];
    ax  = abs_s(gx);
    ay  = abs_s(gy);
    lap = abs_s(c4 - nb);
    case (mode_e'(md))
      MODE_BLUR:  res = (int'(sum) * BLUR_RECIP) >>> 16;
      MODE_SOBX:  res = int'(ax) >>> 2;
      MODE_SOBY:  res = int'(ay) >>> 2;
      MODE_LAP:   res = int'(lap);
      MODE_SHARP: res = int'(c4 + t[1][1] - nb);
`ifdef CONV_SOBEL_MAG_EN
      MODE_MAG:   res = (int'(ax) + int'(ay)) >>> 2;
`endif
      default:    res = int'(t[1][1]);
    endcase
    return CH_WIDTH'(saturate(res, CH_WIDTH));
  endfunction

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    logic [2:0][2:0][CH_WIDTH-1:0] p;
    always_comb begin
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          p[r][c] = win_g[r][c][ch*CH_WIDTH +: CH_WIDTH];
    end
    assign filt[ch*CH_WIDTH +: CH_WIDTH] = filt_ch(p, o_mode_active);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hs_dly  <= '0;
      vs_dly  <= '0;
      vde_dly <= '0;
      data_q  <= '0;
    end else begin
      hs_dly  <= {hs_dly[PIPE_LAT-2:0], vid_in.hsync};
      vs_dly  <= {vs_dly[PIPE_LAT-2:0], vid_in.vsync};
      vde_dly <= {vde_dly[PIPE_LAT-2:0], vid_in.vde};
      data_q  <= vde_dly[PIPE_LAT-2] ? filt : '0;
    end
  end

  assign vid_out.data  = data_q;
  assign vid_out.hsync = hs_dly[PIPE_LAT-1];
  assign vid_out.vsync = vs_dly[PIPE_LAT-1];
  assign vid_out.vde   = vde_dly[PIPE_LAT-1];

endmodule
